pipeline_sequencer: RTL and testbench
=====================================

PIPELINE_SEQUENCER -- requirements
Module: pipeline_sequencer

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 4, number of cycles the pipeline drains after a stop request (legal 1..15).
REQ-002 SHALL have port clk  input  1  main clock; all state updates on rising edge.
REQ-003 SHALL have port arst_n  input  1  reset: one clock; reset is synchronous and active-low.
REQ-004 SHALL have port enable  input  1  start/keep-running request from the testbench/host.
REQ-005 SHALL have port halt_req  input  1  stop request; drain the pipeline, then halt.
REQ-006 SHALL have port mem_read_EX  input  1  the instruction in EX is a load.
REQ-007 SHALL have port regfile_waddr_EX  input  5  destination register of the instruction in EX.
REQ-008 SHALL have ports rs_ID and rt_ID  input  5 each  source registers of the instruction in ID.
REQ-009 SHALL have port uses_rt_ID  input  1  the instruction in ID reads rt.
REQ-010 SHALL have ports branch_taken_MEM and jump_MEM  input  1 each  control transfer resolved in MEM.
REQ-011 SHALL have port pipeline_en  output  5  bit0 IF, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB.
REQ-012 SHALL have ports stalling, flush and busy  output  1 each  bubble insert, squash IF/ID/EX, sequencer active.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DRAIN, HALTED, with a registered state and drain counter.
REQ-014 In IDLE: pipeline_en=5'b00000; enable=1 moves to RUN on the next edge.
REQ-015 In RUN without hazard or flush: pipeline_en=5'b11111, stalling=0, flush=0.
REQ-016 Load-use hazard = mem_read_EX & (regfile_waddr_EX!=0) & ((regfile_waddr_EX==rs_ID) | (uses_rt_ID & regfile_waddr_EX==rt_ID)); evaluated only in RUN.
REQ-017 On a hazard in RUN (same cycle, combinational): pipeline_en=5'b11100, stalling=1; one bubble per load.
REQ-018 On branch_taken_MEM|jump_MEM in RUN: flush=1 for that cycle only, pipeline_en=5'b11111, and stalling forced to 0 (flush wins over hazard).
REQ-019 In RUN, halt_req=1 or enable=0 SHALL move to DRAIN, loading the counter with DRAIN_CYCLES-1; halt_req takes priority over a concurrent hazard or flush (the flush is still output that cycle).
REQ-020 In DRAIN: pipeline_en=5'b11110 (IF frozen), stalling=0, flush=0; decrement each cycle; at counter 0 move to HALTED.
REQ-021 In HALTED: pipeline_en=5'b00000; enable=0 moves to IDLE, otherwise stay.
REQ-022 busy=1 exactly in RUN and DRAIN.
REQ-023 All outputs SHALL be 0 outside RUN except as listed; no output depends on inputs outside RUN.

Reset
REQ-024 arst_n=0 at an edge SHALL force IDLE, counter=0, counters of REQ-026 to 0, from any state including mid-DRAIN.
REQ-025 During and in the cycle after reset: pipeline_en=0, stalling=0, flush=0, busy=0.

Configuration
REQ-026 With PIPELINE_SEQUENCER_PERF_CNT_EN defined: add outputs cycle_cnt (32) counting RUN cycles and stall_cnt (16) counting stalling=1 cycles, both saturating at all-ones.
REQ-027 Without PIPELINE_SEQUENCER_PERF_CNT_EN: those ports and registers SHALL not exist; all other behaviour identical.

Verification
REQ-028 Reset, enable=1 at cycle 0 -> pipeline_en=00000 in cycle 0, 11111 from cycle 1, busy=1.
REQ-029 RUN, mem_read_EX=1, waddr_EX=5, rs_ID=5 -> same cycle pipeline_en=11100, stalling=1; rs_ID=0/waddr_EX=0 case -> no stall.
REQ-030 RUN, hazard and branch_taken_MEM=1 together -> flush=1, stalling=0, pipeline_en=11111.
REQ-031 DRAIN_CYCLES=4, halt_req pulse in RUN -> 4 cycles of 11110, then 00000 and busy=0; enable=0 -> IDLE.
REQ-032 arst_n=0 during cycle 2 of DRAIN -> IDLE next edge, all outputs 0; re-enable restarts cleanly.
REQ-033 With PIPELINE_SEQUENCER_PERF_CNT_EN: 10 RUN cycles with 2 stalls -> cycle_cnt=10, stall_cnt=2.

Source files
------------

// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: run/drain/halt control for a 5-stage pipeline, plus
// load-use stall and branch/jump flush generation while running.
// Optional performance counters: define PIPELINE_SEQUENCER_PERF_CNT_EN.
module pipeline_sequencer #(
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        enable,
  input  logic        halt_req,
  input  logic        mem_read_EX,
  input  logic [4:0]  regfile_waddr_EX,
  input  logic [4:0]  rs_ID,
  input  logic [4:0]  rt_ID,
  input  logic        uses_rt_ID,
  input  logic        branch_taken_MEM,
  input  logic        jump_MEM,
  output logic [4:0]  pipeline_en,
  output logic        stalling,
  output logic        flush,
  output logic        busy
`ifdef PIPELINE_SEQUENCER_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [15:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, HALTED} state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  // Set in the cycle after a stall so a held load-use match only costs one bubble.
  logic       stall_q, stall_d;

  logic in_run, in_drain, hazard, stop, ctl;

  // Outputs: input-dependent only in RUN; forced low while reset is asserted.
  always_comb begin
    in_run   = arst_n && (state_q == RUN);
    in_drain = arst_n && (state_q == DRAIN);
    hazard   = mem_read_EX && (regfile_waddr_EX != 5'd0) &&
               ((regfile_waddr_EX == rs_ID) ||
                (uses_rt_ID && (regfile_waddr_EX == rt_ID)));
    stop     = halt_req || !enable;
    ctl      = branch_taken_MEM || jump_MEM;
    // A flush squashes the dependent instruction, and a stop request ends RUN,
    // so either one overrides the stall.
    stalling = in_run && hazard && !stall_q && !ctl && !stop;
    flush    = in_run && ctl;
    busy     = in_run || in_drain;
    if (in_run)        pipeline_en = stalling ? 5'b11100 : 5'b11111;
    else if (in_drain) pipeline_en = 5'b11110;
    else               pipeline_en = 5'b00000;
  end

  // Next-state logic for the sequencer FSM and drain counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_d = stalling;
    case (state_q)
      IDLE:   if (enable) state_d = RUN;
      RUN:    if (stop) begin
                state_d = DRAIN;
                cnt_d   = 4'(DRAIN_CYCLES - 1);
              end
      DRAIN:  if (cnt_q == 4'd0) state_d = HALTED;
              else               cnt_d   = cnt_q - 4'd1;
      HALTED: if (!enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      stall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

`ifdef PIPELINE_SEQUENCER_PERF_CNT_EN
  logic [31:0] cycle_cnt_q;
  logic [15:0] stall_cnt_q;

  // Saturating counts of RUN cycles and stall cycles.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      cycle_cnt_q <= 32'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      if (in_run && !(&cycle_cnt_q))   cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if (stalling && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Testbench for pipeline_sequencer: directed scenarios plus a randomized run
// compared against a behavioural reference model.
module tb_pipeline_sequencer;
  localparam int DC = 4;

  logic       clk;
  logic       arst_n, enable, halt_req, mem_read_EX, uses_rt_ID;
  logic       branch_taken_MEM, jump_MEM;
  logic [4:0] regfile_waddr_EX, rs_ID, rt_ID;
  logic [4:0] pipeline_en;
  logic       stalling, flush, busy;
`ifdef PIPELINE_SEQUENCER_PERF_CNT_EN
  logic [31:0] cycle_cnt;
  logic [15:0] stall_cnt;
`endif

  pipeline_sequencer #(.DRAIN_CYCLES(DC)) dut (
    .clk(clk), .arst_n(arst_n), .enable(enable), .halt_req(halt_req),
    .mem_read_EX(mem_read_EX), .regfile_waddr_EX(regfile_waddr_EX),
    .rs_ID(rs_ID), .rt_ID(rt_ID), .uses_rt_ID(uses_rt_ID),
    .branch_taken_MEM(branch_taken_MEM), .jump_MEM(jump_MEM),
    .pipeline_en(pipeline_en), .stalling(stalling), .flush(flush), .busy(busy)
`ifdef PIPELINE_SEQUENCER_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model: operating mode, remaining drain cycles, last-cycle stall.
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_HALT = 3;
  int          m_mode = M_IDLE;
  int          m_left = 0;
  bit          m_prev_stall = 0;
  longint      m_cyc = 0, m_stl = 0;

  // Expected outputs for the cycle currently being sampled.
  logic [4:0]  e_pe;
  logic        e_st, e_fl, e_busy;
  longint      e_cyc, e_stl;

  // Drive one cycle of inputs, compute expected outputs, advance the model.
  task automatic tick(input logic r, e, h, mr, input logic [4:0] wa, rs, rt,
                      input logic urt, br, jp);
    bit run, drn, haz, stop, ctl;
    @(negedge clk);
    arst_n = r; enable = e; halt_req = h; mem_read_EX = mr;
    regfile_waddr_EX = wa; rs_ID = rs; rt_ID = rt; uses_rt_ID = urt;
    branch_taken_MEM = br; jump_MEM = jp;
    #2;
    run  = r && (m_mode == M_RUN);
    drn  = r && (m_mode == M_DRAIN);
    haz  = mr && (wa != 0) && ((wa == rs) || (urt && (wa == rt)));
    stop = h || !e;
    ctl  = br || jp;
    e_fl   = run && ctl;
    e_st   = run && haz && !m_prev_stall && !ctl && !stop;
    e_pe   = run ? (e_st ? 5'b11100 : 5'b11111) : (drn ? 5'b11110 : 5'b00000);
    e_busy = run || drn;
    e_cyc  = m_cyc;
    e_stl  = m_stl;
    if (!r) begin
      m_mode = M_IDLE; m_left = 0; m_prev_stall = 0; m_cyc = 0; m_stl = 0;
    end else begin
      if (run && m_cyc < 64'hFFFF_FFFF) m_cyc++;
      if (e_st && m_stl < 64'hFFFF) m_stl++;
      m_prev_stall = e_st;
      case (m_mode)
        M_IDLE:  if (e) m_mode = M_RUN;
        M_RUN:   if (stop) begin m_mode = M_DRAIN; m_left = DC; end
        M_DRAIN: begin m_left--; if (m_left == 0) m_mode = M_HALT; end
        default: if (!e) m_mode = M_IDLE;
      endcase
    end
  endtask

  task automatic ctl_tick(input logic e, h);
    tick(1'b1, e, h, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    tick(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    total_cnt++;
    if ({pipeline_en, stalling, flush, busy} !== 8'b0)
      $display("FAIL reset_during: got %b expected 00000000", {pipeline_en, stalling, flush, busy});
    else pass_cnt++;
    ctl_tick(1'b0, 1'b0);
    total_cnt++;
    if ({pipeline_en, stalling, flush, busy} !== 8'b0)
      $display("FAIL reset_after: got %b expected 00000000", {pipeline_en, stalling, flush, busy});
    else pass_cnt++;
  endtask

  task automatic test_start();
    tick(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    ctl_tick(1'b1, 1'b0);
    total_cnt++;
    if (pipeline_en !== 5'b00000 || busy !== 1'b0)
      $display("FAIL start_cycle0: got en=%b busy=%b expected en=00000 busy=0", pipeline_en, busy);
    else pass_cnt++;
    for (int i = 0; i < 2; i++) begin
      ctl_tick(1'b1, 1'b0);
      total_cnt++;
      if (pipeline_en !== 5'b11111 || busy !== 1'b1 || stalling !== 1'b0 || flush !== 1'b0)
        $display("FAIL start_run%0d: got en=%b busy=%b st=%b fl=%b expected en=11111 busy=1 st=0 fl=0",
                 i, pipeline_en, busy, stalling, flush);
      else pass_cnt++;
    end
  endtask

  task automatic test_hazard();
    // rs match
    tick(1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
    total_cnt++;
    if (pipeline_en !== 5'b11100 || stalling !== 1'b1)
      $display("FAIL hazard_rs: got en=%b st=%b expected en=11100 st=1", pipeline_en, stalling);
    else pass_cnt++;
    // same load still in EX the next cycle: only one bubble
    tick(1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
    total_cnt++;
    if (pipeline_en !== 5'b11111 || stalling !== 1'b0)
      $display("FAIL hazard_one_bubble: got en=%b st=%b expected en=11111 st=0", pipeline_en, stalling);
    else pass_cnt++;
    // register 0 never creates a hazard
    tick(1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    total_cnt++;
    if (pipeline_en !== 5'b11111 || stalling !== 1'b0)
      $display("FAIL hazard_r0: got en=%b st=%b expected en=11111 st=0", pipeline_en, stalling);
    else pass_cnt++;
    // rt match ignored when rt is not read
    tick(1'b1, 1'b1, 1'b0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0);
    total_cnt++;
    if (stalling !== 1'b0)
      $display("FAIL hazard_rt_unused: got st=%b expected st=0", stalling);
    else pass_cnt++;
    tick(1'b1, 1'b1, 1'b0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0);
    total_cnt++;
    if (pipeline_en !== 5'b11100 || stalling !== 1'b1)
      $display("FAIL hazard_rt: got en=%b st=%b expected en=11100 st=1", pipeline_en, stalling);
    else pass_cnt++;
    // not a load
    tick(1'b1, 1'b1, 1'b0, 1'b0, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0);
    total_cnt++;
    if (stalling !== 1'b0)
      $display("FAIL hazard_noload: got st=%b expected st=0", stalling);
    else pass_cnt++;
  endtask

  task automatic test_flush();
    tick(1'b1, 1'b1, 1'b0, 1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b1, 1'b0);
    total_cnt++;
    if (flush !== 1'b1 || stalling !== 1'b0 || pipeline_en !== 5'b11111)
      $display("FAIL flush_vs_hazard: got fl=%b st=%b en=%b expected fl=1 st=0 en=11111",
               flush, stalling, pipeline_en);
    else pass_cnt++;
    tick(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    total_cnt++;
    if (flush !== 1'b1)
      $display("FAIL flush_jump: got fl=%b expected fl=1", flush);
    else pass_cnt++;
    ctl_tick(1'b1, 1'b0);
    total_cnt++;
    if (flush !== 1'b0)
      $display("FAIL flush_clear: got fl=%b expected fl=0", flush);
    else pass_cnt++;
  endtask

  task automatic test_drain();
    // halt with concurrent hazard and branch: flush shown, no stall
    tick(1'b1, 1'b1, 1'b1, 1'b1, 5'd6, 5'd6, 5'd0, 1'b0, 1'b1, 1'b0);
    total_cnt++;
    if (flush !== 1'b1 || stalling !== 1'b0 || busy !== 1'b1)
      $display("FAIL halt_priority: got fl=%b st=%b busy=%b expected fl=1 st=0 busy=1",
               flush, stalling, busy);
    else pass_cnt++;
    for (int i = 0; i < DC; i++) begin
      tick(1'b1, 1'b1, 1'b0, 1'b1, 5'd6, 5'd6, 5'd0, 1'b0, 1'b1, 1'b0);
      total_cnt++;
      if ({pipeline_en, stalling, flush, busy} !== 8'b11110_001)
        $display("FAIL drain_%0d: got %b expected 11110001", i, {pipeline_en, stalling, flush, busy});
      else pass_cnt++;
    end
    ctl_tick(1'b1, 1'b0);
    total_cnt++;
    if ({pipeline_en, stalling, flush, busy} !== 8'b0)
      $display("FAIL halted: got %b expected 00000000", {pipeline_en, stalling, flush, busy});
    else pass_cnt++;
    ctl_tick(1'b1, 1'b0);   // still halted while enable held
    ctl_tick(1'b0, 1'b0);   // back to IDLE
    ctl_tick(1'b1, 1'b0);   // IDLE -> RUN
    total_cnt++;
    if (busy !== 1'b0)
      $display("FAIL halted_to_idle: got busy=%b expected 0", busy);
    else pass_cnt++;
    ctl_tick(1'b1, 1'b0);
    total_cnt++;
    if (pipeline_en !== 5'b11111 || busy !== 1'b1)
      $display("FAIL rerun: got en=%b busy=%b expected en=11111 busy=1", pipeline_en, busy);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_drain();
    ctl_tick(1'b1, 1'b1);            // RUN, stop requested
    ctl_tick(1'b1, 1'b0);            // DRAIN cycle 1
    tick(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);  // DRAIN cycle 2, reset
    total_cnt++;
    if ({pipeline_en, stalling, flush, busy} !== 8'b0)
      $display("FAIL reset_in_drain: got %b expected 00000000", {pipeline_en, stalling, flush, busy});
    else pass_cnt++;
    ctl_tick(1'b1, 1'b0);            // IDLE, enable -> RUN
    total_cnt++;
    if ({pipeline_en, stalling, flush, busy} !== 8'b0)
      $display("FAIL idle_after_reset: got %b expected 00000000", {pipeline_en, stalling, flush, busy});
    else pass_cnt++;
    ctl_tick(1'b1, 1'b0);
    total_cnt++;
    if (pipeline_en !== 5'b11111 || busy !== 1'b1)
      $display("FAIL restart: got en=%b busy=%b expected en=11111 busy=1", pipeline_en, busy);
    else pass_cnt++;
  endtask

`ifdef PIPELINE_SEQUENCER_PERF_CNT_EN
  task automatic test_perf();
    tick(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    ctl_tick(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (i == 2 || i == 6)
        tick(1'b1, 1'b1, 1'b0, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0);
      else
        ctl_tick(1'b1, 1'b0);
    end
    ctl_tick(1'b1, 1'b0);
    total_cnt++;
    if (cycle_cnt !== 32'd10 || stall_cnt !== 16'd2)
      $display("FAIL perf_counts: got cyc=%0d stl=%0d expected cyc=10 stl=2", cycle_cnt, stall_cnt);
    else pass_cnt++;
  endtask
`endif

  task automatic test_random();
    logic r, e, h, mr, urt, br, jp;
    logic [4:0] wa, rs, rt;
    for (int i = 0; i < 400; i++) begin
      r   = ($urandom_range(0, 79) != 0);
      e   = ($urandom_range(0, 19) != 0);
      h   = ($urandom_range(0, 24) == 0);
      mr  = 1'($urandom_range(0, 1));
      wa  = 5'($urandom_range(0, 3));
      rs  = 5'($urandom_range(0, 3));
      rt  = 5'($urandom_range(0, 3));
      urt = 1'($urandom_range(0, 1));
      br  = ($urandom_range(0, 9) == 0);
      jp  = ($urandom_range(0, 9) == 0);
      tick(r, e, h, mr, wa, rs, rt, urt, br, jp);
      total_cnt++;
      if ({pipeline_en, stalling, flush, busy} !== {e_pe, e_st, e_fl, e_busy})
        $display("FAIL random_%0d: got en=%b st=%b fl=%b busy=%b expected en=%b st=%b fl=%b busy=%b",
                 i, pipeline_en, stalling, flush, busy, e_pe, e_st, e_fl, e_busy);
      else pass_cnt++;
`ifdef PIPELINE_SEQUENCER_PERF_CNT_EN
      total_cnt++;
      if (64'(cycle_cnt) !== e_cyc || 64'(stall_cnt) !== e_stl)
        $display("FAIL random_perf_%0d: got cyc=%0d stl=%0d expected cyc=%0d stl=%0d",
                 i, cycle_cnt, stall_cnt, e_cyc, e_stl);
      else pass_cnt++;
`endif
    end
  endtask

  initial begin
    arst_n = 1'b0; enable = 1'b0; halt_req = 1'b0; mem_read_EX = 1'b0;
    regfile_waddr_EX = 5'd0; rs_ID = 5'd0; rt_ID = 5'd0; uses_rt_ID = 1'b0;
    branch_taken_MEM = 1'b0; jump_MEM = 1'b0;
    test_reset();
    test_start();
    test_hazard();
    test_flush();
    test_drain();
    test_reset_mid_drain();
`ifdef PIPELINE_SEQUENCER_PERF_CNT_EN
    test_perf();
`endif
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
